seq_comparator: RTL and testbench
=================================

Name: seq_comparator

Overview:
Parametrised, registered magnitude comparator with valid/ready handshakes on input and output. Compares two WIDTH-bit operands chunk by chunk, starting at the MSB chunk and processing CHUNK bits per cycle. Stops early at the first differing chunk. Supports unsigned and two's-complement signed modes, selected per transaction. Sits on datapaths where a wide compare must not sit in one combinational cone; it is the multi-bit, handshaked successor of the team's 4-bit combinational comparator.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; must be between 1 and WIDTH inclusive.
NUM_CHUNKS, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept a transaction
a  input  WIDTH  operand A
b  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
gt  output  1  A > B
lt  output  1  A < B
eq  output  1  A == B

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. It is sampled on the rising edge of clk and overrides all other activity.
- Reset values: state=IDLE, out_valid=0, gt=lt=eq=0, captured operands=0, chunk index=NUM_CHUNKS-1. in_ready=1 in the first cycle after reset.
- FSM states: IDLE, CMP, DONE.
- in_ready: combinational, equal to (state==IDLE).
- out_valid: registered, equal to (state==DONE).
- IDLE: when in_valid is high, on the clock edge:
  - register a, b and signed_mode;
  - set idx=NUM_CHUNKS-1;
  - go to CMP.
- CMP: each cycle compares chunk idx of the captured A and B (bits idx*CHUNK+CHUNK-1 down to idx*CHUNK) as unsigned values.
  - When signed_mode=1 and idx=NUM_CHUNKS-1, invert the top bit of both chunks before comparing (offset-binary trick).
  - If the chunks differ: load gt/lt from the chunk result, eq=0, go to DONE.
  - If the chunks are equal and idx=0: eq=1, gt=lt=0, go to DONE.
  - Otherwise: decrement idx and stay in CMP.
- DONE: gt/lt/eq are held stable and exactly one of them is 1.
  - On out_valid && out_ready: clear gt/lt/eq to 0 and go to IDLE.
- Latency: k cycles from the accept edge to out_valid=1, where k = number of chunks examined (1..NUM_CHUNKS).
  - Best case 1 (MSB chunk differs); worst case NUM_CHUNKS (equal operands, or a difference only in chunk 0).
- Throughput: one transaction at a time. in_ready=0 throughout CMP and DONE. After a result is accepted, the earliest next accept is the cycle after the out handshake.
- Input stability: a, b and signed_mode may change freely after acceptance. Changes on a, b or in_valid outside IDLE have no effect.
- Backpressure: out_ready=0 holds DONE indefinitely. gt/lt/eq and out_valid remain unchanged.
- Outside DONE: gt=lt=eq=0.
- Reset mid-operation (CMP or DONE): the transaction is dropped with no result. The next cycle is IDLE with reset values.
- Simultaneous rst and handshake: rst wins; no capture and no result.
- CHUNK=WIDTH: degenerates to a 1-cycle registered compare; all behaviour above still holds.

Decomposition:
- Package cmp_pkg holds:
  - state enum {IDLE, CMP, DONE};
  - a 3-bit result typedef {gt, lt, eq} with constants RES_GT=3'b100, RES_LT=3'b010, RES_EQ=3'b001, RES_NONE=3'b000.
- Sub-module chunk_cmp: purely combinational CHUNK-wide compare.
  - Inputs: two chunks and an invert_msb flag.
  - Outputs: gt, lt, eq.
  - Instantiated once and fed by an idx-driven mux.
- The top-level FSM, operand registers and index counter live in seq_comparator.
- Parameter legality is checked with an elaboration-time assertion.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. a=0x1234, b=0x1234, unsigned, out_ready=1 -> out_valid rises 4 cycles after accept with eq=1, gt=lt=0; in_ready=0 for 5 cycles in total.
2. a=0x8000, b=0x7FFF: unsigned -> gt=1 after 1 cycle; the same operands with signed_mode=1 -> lt=1 after 1 cycle.
3. a=0x12F4, b=0x1304, unsigned -> chunk 3 equal, chunk 2 gives 2<3, so lt=1 with out_valid 2 cycles after accept.
4. a=0xFFFE, b=0xFFFF, signed -> lt=1 after 4 cycles. Hold out_ready=0 for 6 cycles while pulsing in_valid with new operands -> out_valid, lt and in_ready=0 all stay stable; the new operands are ignored; the result is consumed when out_ready=1 and in_ready=1 on the next cycle.
5. Assert rst for one cycle while in CMP (a=0x0001, b=0x0000, second CMP cycle) -> next cycle state IDLE, out_valid=0, gt=lt=eq=0, in_ready=1; that transaction never produces a result.
6. Back-to-back: send 0x0010 vs 0x000F with out_ready tied to 1, then 0x0000 vs 0x0000 signed -> first result gt=1 at 3 cycles, second eq=1 at 4 cycles; the second accept occurs exactly one cycle after the first out handshake.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared types for the sequential magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } result_t;

    localparam result_t RES_GT   = 3'b100;
    localparam result_t RES_LT   = 3'b010;
    localparam result_t RES_EQ   = 3'b001;
    localparam result_t RES_NONE = 3'b000;

endpackage

`default_nettype wire

// File: rtl/chunk_cmp.sv
`default_nettype none
// ============================================================================
// Module      : chunk_cmp
// Description : Combinational CHUNK-wide unsigned compare with optional MSB flip.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] chunk_a,
    input  logic [CHUNK-1:0] chunk_b,
    input  logic             invert_msb,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        w_mask            = '0;
        w_mask[CHUNK-1]   = invert_msb;
    end

    assign w_a = chunk_a ^ w_mask;
    assign w_b = chunk_b ^ w_mask;

    assign gt = (w_a > w_b);
    assign lt = (w_a < w_b);
    assign eq = (w_a == w_b);

endmodule

`default_nettype wire

// File: rtl/seq_comparator.sv
`default_nettype none
// ============================================================================
// Module      : seq_comparator
// Description : Handshaked magnitude comparator walking CHUNK bits per cycle
//               from the MSB chunk, stopping at the first difference.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int C_SLOTS    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CHUNKS - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("seq_comparator: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IDX_W-1:0] r_idx;
    result_t          r_res;
    logic             r_out_valid;

    logic [CHUNK-1:0] w_slots_a [C_SLOTS];
    logic [CHUNK-1:0] w_slots_b [C_SLOTS];
    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic             w_invert_msb;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;

    // Index space padded to a power of two so the mux select needs no range guard.
    for (genvar i = 0; i < C_SLOTS; i++) begin : g_split
        if (i < NUM_CHUNKS) begin : g_real
            assign w_slots_a[i] = r_a[i*CHUNK +: CHUNK];
            assign w_slots_b[i] = r_b[i*CHUNK +: CHUNK];
        end else begin : g_pad
            assign w_slots_a[i] = '0;
            assign w_slots_b[i] = '0;
        end
    end

    assign w_chunk_a    = w_slots_a[r_idx];
    assign w_chunk_b    = w_slots_b[r_idx];
    assign w_invert_msb = r_signed && (r_idx == c_last_idx);

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .chunk_a    (w_chunk_a),
        .chunk_b    (w_chunk_b),
        .invert_msb (w_invert_msb),
        .gt         (w_gt),
        .lt         (w_lt),
        .eq         (w_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_idx       <= c_last_idx;
            r_res       <= RES_NONE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_idx    <= c_last_idx;
                        r_state  <= CMP;
                    end
                end
                CMP: begin
                    if (!w_eq) begin
                        r_res       <= w_gt ? RES_GT : RES_LT;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_idx == '0) begin
                        r_res       <= RES_EQ;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_res       <= RES_NONE;
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_res       <= RES_NONE;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign gt        = r_res.gt;
    assign lt        = r_res.lt;
    assign eq        = r_res.eq;

endmodule

`default_nettype wire

// File: tb/tb_seq_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_comparator
// Description : Self-checking bench for seq_comparator (WIDTH=16, CHUNK=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic        gt;
    logic        lt;
    logic        eq;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[11];
    int   total = 0;
    int   bad   = 0;

    seq_comparator #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gt          (gt),
        .lt          (lt),
        .eq          (eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: whole-word compare plus count of chunks scanned from the MSB.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic sm);
        exp_t e;
        bit   found = 1'b0;
        e.lat = 0;
        for (int i = 3; i >= 0; i--) begin
            if (!found) begin
                e.lat++;
                if (av[i*4 +: 4] != bv[i*4 +: 4]) found = 1'b1;
            end
        end
        if (av == bv)
            e.res = 3'b001;
        else if (sm ? ($signed(av) > $signed(bv)) : (av > bv))
            e.res = 3'b100;
        else
            e.res = 3'b010;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sm, input exp_t e);
        int n = 0;
        a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 50), 1);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic collect(input string name);
        int   n    = 0;
        bit   busy = 1'b1;
        exp_t e;
        while (!out_valid && n < 40) begin
            if (in_ready || gt || lt || eq) busy = 1'b0;
            @(negedge clk);
            n++;
        end
        if (in_ready) busy = 1'b0;
        check({name, "_sb_nonempty"}, 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) e = sbq.pop_front();
        else e = '{res: 3'b000, lat: 0};
        check({name, "_latency"}, 32'(n), 32'(e.lat));
        check({name, "_result"}, {29'd0, gt, lt, eq}, {29'd0, e.res});
        check({name, "_busy"}, 32'(busy), 1);
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_idle_after"}, {29'd0, in_ready, out_valid, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
        check({name, "_cleared"}, {29'd0, gt, lt, eq}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 3'b001, 4};
        vecs[1]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
        vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 1};
        vecs[3]  = '{16'h12F4, 16'h1304, 1'b0, 3'b010, 2};
        vecs[4]  = '{16'h0010, 16'h000F, 1'b0, 3'b100, 3};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 3'b001, 4};
        vecs[6]  = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b010, 4};
        vecs[7]  = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};
        vecs[8]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b010, 1};
        vecs[9]  = '{16'h0001, 16'hFFFF, 1'b0, 3'b010, 1};
        vecs[10] = '{16'h0005, 16'h0003, 1'b1, 3'b100, 4};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 1);
        check("reset_outputs", {28'd0, out_valid, gt, lt, eq}, 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sm, '{res: vecs[i].res, lat: vecs[i].lat});
            collect($sformatf("vec%0d", i));
            consume($sformatf("vec%0d", i));
        end

        // Random operands that differ in at most one bit, with random backpressure.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            int          hold;
            bit          stable = 1'b1;
            ra   = 16'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? ra : ra ^ (16'h1 << $urandom_range(0, 15));
            rs   = 1'($urandom);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            issue(ra, rb, rs, model(ra, rb, rs));
            collect("rand");
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!out_valid || in_ready || (gt + lt + eq) != 2'd1) stable = 1'b0;
            end
            check("rand_hold_stable", 32'(stable), 1);
            consume("rand");
        end

        // Backpressure with ignored new operands on in_valid.
        begin
            bit stable = 1'b1;
            out_ready = 1'b0;
            issue(16'hFFFE, 16'hFFFF, 1'b1, '{res: 3'b010, lat: 4});
            collect("bp");
            for (int k = 0; k < 6; k++) begin
                in_valid = k[0];
                a = 16'($urandom);
                b = 16'($urandom);
                @(negedge clk);
                if (!out_valid || in_ready || {gt, lt, eq} != 3'b010) stable = 1'b0;
            end
            in_valid = 1'b0;
            check("bp_stable", 32'(stable), 1);
            consume("bp");
            stable = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (out_valid || !in_ready) stable = 1'b0;
            end
            check("bp_new_operands_ignored", 32'(stable), 1);
        end

        // Reset during the second CMP cycle drops the transaction.
        begin
            bit quiet = 1'b1;
            out_ready = 1'b1;
            issue(16'h0001, 16'h0000, 1'b0, '{res: 3'b100, lat: 4});
            void'(sbq.pop_back());
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_in_ready", {31'd0, in_ready}, 1);
            check("midrst_outputs", {28'd0, out_valid, gt, lt, eq}, 32'd0);
            repeat (6) begin
                @(negedge clk);
                if (out_valid || !in_ready) quiet = 1'b0;
            end
            check("midrst_no_result", 32'(quiet), 1);

            rst = 1'b1; in_valid = 1'b1; a = 16'h0005; b = 16'h0003; signed_mode = 1'b0;
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0;
            check("rst_vs_accept_idle", {31'd0, in_ready}, 1);
            quiet = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (out_valid || !in_ready) quiet = 1'b0;
            end
            check("rst_vs_accept_no_result", 32'(quiet), 1);
        end

        // Back-to-back: next accept lands one cycle after the out handshake.
        out_ready = 1'b1;
        issue(16'h0010, 16'h000F, 1'b0, '{res: 3'b100, lat: 3});
        collect("b2b_first");
        a = 16'h0000; b = 16'h0000; signed_mode = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_ready_after_handshake", {30'd0, in_ready, out_valid}, 32'b10);
        sbq.push_back('{res: 3'b001, lat: 4});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_second_accepted", {31'd0, in_ready}, 0);
        collect("b2b_second");
        consume("b2b_second");

        check("scoreboard_drained", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
